fifo_rd_ctrl: RTL and testbench

//   Read-side controller for the 256x9 FIFO storage array in the APB-to-FIFO path.
//   The APB writer pushes entries through the array's write port and publishes its write pointer.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_out_reg.sv | 41 ++++
 rtl/fifo_rd_ctrl.sv | 75 +++++++
 tb/tb_fifo_rd_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing and pointer helpers for the 256x9 APB-to-FIFO path.
//   FIFO_DW    array word width
//   FIFO_AW    array address width
//   FIFO_DEPTH number of array entries
//   ptr_t      pointer with one extra wrap bit above the address
//   ptr_level  entries between a write and a read pointer (modulo pointer range)
package fifo_pkg;
  localparam int FIFO_DW    = 9;
  localparam int FIFO_AW    = 8;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;

  typedef logic [FIFO_AW:0] ptr_t;

  // Wrap bit makes plain subtraction give 0..DEPTH for a well-behaved writer.
  function automatic ptr_t ptr_level(input ptr_t wr, input ptr_t rd);
    return wr - rd;
  endfunction
endpackage

// File: rtl/fifo_out_reg.sv
// fifo_out_reg: one-entry valid/ready output register.
//   clk, rst_n   clock, synchronous active-low reset
//   clr          drop the held entry (dout keeps its last value)
//   load         capture data; wins over a same-cycle consume so the stage
//                can take one entry per cycle
//   data         entry to capture on load
//   ready        downstream accepts the held entry this cycle
//   dout         held entry
//   dout_valid   dout holds an entry
module fifo_out_reg #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] data,
  input  logic          ready,
  output logic [DW-1:0] dout,
  output logic          dout_valid
);
  logic [DW-1:0] dout_q;
  logic          vld_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else if (clr) begin
      vld_q  <= 1'b0;
    end else if (load) begin
      dout_q <= data;
      vld_q  <= 1'b1;
    end else if (ready) begin
      vld_q  <= 1'b0;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = vld_q;
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller for the 256x9 FIFO array.
//   clk, rst_n   clock, synchronous active-low reset (overrides flush)
//   wr_ptr       writer pointer, MSB is the wrap bit
//   mem_addr     array read address (combinational from rd_ptr)
//   mem_rdata    array read data, combinational from mem_addr
//   rd_ptr       read pointer returned to the writer for its full check
//   dout*        downstream valid/ready stream through one output register
//   flush        discard everything up to the sampled wr_ptr
//   level        unpopped entries in the array, empty when zero
//   ovf_err      sticky: level went above DEPTH
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DW = FIFO_DW,
  parameter int AW = FIFO_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW:0]   wr_ptr,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW:0]   rd_ptr,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  input  logic          flush,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          ovf_err
);
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        ovf_q, ovf_d;
  logic        pop;
  logic        over;

  assign level    = wr_ptr - rd_ptr_q;
  assign empty    = (wr_ptr == rd_ptr_q);
  assign mem_addr = rd_ptr_q[AW-1:0];
  assign rd_ptr   = rd_ptr_q;
  assign ovf_err  = ovf_q;

  // level > DEPTH: wrap bit set with any low bit also set.
  assign over = level[AW] & (|level[AW-1:0]);

  // Pop whenever the output stage is free or being drained this cycle.
  assign pop = !empty && (!dout_valid || dout_ready) && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (flush)    rd_ptr_d = wr_ptr;
    else if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    ovf_d = ovf_q | over;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  fifo_out_reg #(.DW(DW)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .load      (pop),
    .data      (mem_rdata),
    .ready     (dout_ready),
    .dout      (dout),
    .dout_valid(dout_valid)
  );
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, flush, dout_ready;
  int         wr_cnt;              // unbounded count of entries ever written
  logic [8:0] wr_ptr;
  assign wr_ptr = wr_cnt[8:0];

  logic [8:0] mem  [256];
  logic [8:0] hist [2048];         // entry n of the stream, by absolute index
  logic [7:0] mem_addr;
  logic [8:0] mem_rdata;
  assign mem_rdata = mem[mem_addr];

  logic [8:0] rd_ptr, dout, level;
  logic       dout_valid, empty, ovf_err;

  fifo_rd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_ptr(wr_ptr), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .rd_ptr(rd_ptr), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .flush(flush),
    .level(level), .empty(empty), .ovf_err(ovf_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Model: counts of entries written/popped plus the output-stage contents.
  int         m_rd = 0;
  bit         m_vld = 0;
  bit         m_ovf = 0;
  logic [8:0] m_dout = '0;

  always @(posedge clk) begin
    int lvl;
    lvl = wr_cnt - m_rd;
    if (!rst_n) begin
      m_rd = 0; m_vld = 0; m_dout = '0; m_ovf = 0;
    end else begin
      if (lvl > 256) m_ovf = 1;
      if (flush) begin
        m_rd  = wr_cnt;
        m_vld = 0;
      end else if (lvl > 0 && (!m_vld || dout_ready)) begin
        m_dout = hist[m_rd % 2048];
        m_rd   = m_rd + 1;
        m_vld  = 1;
      end else if (dout_ready) begin
        m_vld = 0;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    chk("rd_ptr",     rd_ptr,     m_rd % 512);
    chk("mem_addr",   mem_addr,   m_rd % 256);
    chk("dout_valid", dout_valid, m_vld);
    if (m_vld) chk("dout", dout, m_dout);
    chk("level",      level,      (wr_cnt - m_rd) & 511);
    chk("empty",      empty,      ((wr_cnt - m_rd) & 511) == 0);
    chk("ovf_err",    ovf_err,    m_ovf);
  end

  task automatic push(input logic [8:0] d);
    hist[wr_cnt % 2048] = d;
    mem[wr_cnt % 256]   = d;
    wr_cnt++;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 256; k++)  mem[k]  = '0;
    for (int k = 0; k < 2048; k++) hist[k] = '0;
    rst_n = 1'b0; flush = 1'b0; dout_ready = 1'b1; wr_cnt = 0;
    for (int k = 0; k < 5; k++) push(9'h100 + 9'(k));

    // 1: reset with wr_ptr=5
    step(2);
    chk("t1_rd_ptr", rd_ptr, 0);
    chk("t1_valid", dout_valid, 0);
    chk("t1_ovf", ovf_err, 0);
    chk("t1_level", level, 5);
    rst_n = 1'b1;
    step(1);
    chk("t1_first_valid", dout_valid, 1);
    chk("t1_first_dout", dout, 9'h100);
    step(6);

    rst_n = 1'b0; wr_cnt = 0;
    step(2);
    rst_n = 1'b1;
    step(1);

    // 2: single entry into an empty array
    push(9'h1A5);
    step(1);
    chk("t2_valid", dout_valid, 1);
    chk("t2_dout", dout, 9'h1A5);
    chk("t2_rd_ptr", rd_ptr, 1);
    chk("t2_empty", empty, 1);
    step(1);
    chk("t2_drained", dout_valid, 0);

    // 4: backpressure
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(9'h0B0 + 9'(i));
      step(1);
    end
    step(6);
    chk("t4_hold_dout", dout, 9'h0B0);
    chk("t4_hold_valid", dout_valid, 1);
    chk("t4_hold_rd_ptr", rd_ptr, 2);
    chk("t4_hold_level", level, 3);
    dout_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step(1);
      chk("t4_stream_dout", dout, 9'h0B0 + i);
    end
    step(1);
    chk("t4_done", dout_valid, 0);

    // 5: flush with 10 queued
    dout_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push(9'h0C0 + 9'(i));
      step(1);
    end
    chk("t5_pre_valid", dout_valid, 1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("t5_valid", dout_valid, 0);
    chk("t5_rd_ptr", rd_ptr, 15);
    chk("t5_level", level, 0);
    push(9'h1C3);
    dout_ready = 1'b1;
    step(1);
    chk("t5_after_valid", dout_valid, 1);
    chk("t5_after_dout", dout, 9'h1C3);
    step(1);

    // advance the pointers near the top so the stream wraps
    dout_ready = 1'b0;
    for (int i = 0; i < 250; i++) begin
      push(9'(i * 37));
      step(1);
    end
    flush = 1'b1;
    step(1);
    flush = 1'b0;

    // 3: 300-entry stream, ready held high
    dout_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      push(9'(i * 13 + 5));
      step(1);
    end
    step(3);
    chk("t3_rd_ptr_wrapped", rd_ptr, 54);
    chk("t3_valid", dout_valid, 0);
    chk("t3_ovf", ovf_err, 0);

    // 6: overrun
    dout_ready = 1'b0;
    push(9'h055);
    step(2);
    chk("t6_pre_valid", dout_valid, 1);
    wr_cnt = wr_cnt + 257;
    step(1);
    chk("t6_ovf_set", ovf_err, 1);
    wr_cnt = wr_cnt - 257;
    step(3);
    chk("t6_ovf_sticky", ovf_err, 1);
    rst_n = 1'b0; wr_cnt = 0;
    step(1);
    chk("t6_ovf_cleared", ovf_err, 0);
    chk("t6_rd_ptr", rd_ptr, 0);
    chk("t6_valid", dout_valid, 0);
    rst_n = 1'b1;
    step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
